// File: rtl/deserializer_if.sv
// Serial-in / word-out bus between the serial source, the deserializer and the word queue.
// Ports: data_in/write_in (serial bit + qualifier), ack_in (queue accepted the word),
//        data_out/data_ready (assembled word), status_out (busy), bit_cnt_out, words_out.
interface deserializer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             data_in;
    logic             write_in;
    logic             ack_in;
    logic [WIDTH-1:0] data_out;
    logic             data_ready;
    logic             status_out;
    logic [3:0]       bit_cnt_out;
    logic [CNT_W-1:0] words_out;

    // Source/queue side: drives serial bits and the queue acknowledge.
    modport master (
        output data_in, write_in, ack_in,
        input  data_out, data_ready, status_out, bit_cnt_out, words_out
    );

    // Deserializer side.
    modport slave (
        input  data_in, write_in, ack_in,
        output data_out, data_ready, status_out, bit_cnt_out, words_out
    );
endinterface

// File: rtl/deserializer.sv
// Serial-to-parallel stage: assembles WIDTH-bit words MSB-first and hands them to the word queue.
// Latency: word visible the cycle after its last bit is accepted; all outputs registered.
// Backpressure: status_out stays high while a word awaits ack_in; serial bits offered then are dropped.
// Ports: clock, reset (async, active-high), bus (deserializer_if.slave).
module deserializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic          clock,
    input  logic          reset,
    deserializer_if.slave bus
);
    typedef enum logic {
        COLLECT  = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    localparam logic [3:0]       LAST_BIT = 4'(WIDTH - 1);
    localparam logic [CNT_W-1:0] WORD_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    // Only WIDTH-1 bits need to be kept: the final bit goes straight from data_in into data_out.
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] words_q, words_d;

    logic             accept_bit;
    logic             last_bit;

    assign accept_bit = (state_q == COLLECT) && bus.write_in;
    assign last_bit   = accept_bit && (bit_cnt_q == LAST_BIT);

    // State register and datapath flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= COLLECT;
            shift_q   <= '0;
            data_q    <= '0;
            bit_cnt_q <= '0;
            words_q   <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            bit_cnt_q <= bit_cnt_d;
            words_q   <= words_d;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        data_d    = data_q;
        bit_cnt_d = bit_cnt_q;
        words_d   = words_q;
        case (state_q)
            COLLECT: begin
                if (accept_bit) begin
                    if (last_bit) begin
                        data_d    = {shift_q, bus.data_in};
                        shift_d   = '0;
                        bit_cnt_d = '0;
                        state_d   = WAIT_ACK;
                    end else begin
                        shift_d   = {shift_q[WIDTH-3:0], bus.data_in};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            WAIT_ACK: begin
                // Any write_in here is dropped; an ack on the same edge still wins.
                if (bus.ack_in) begin
                    state_d = COLLECT;
                    if (words_q != '1) begin
                        words_d = words_q + WORD_ONE;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Outputs decode from flops only.
    always_comb begin
        bus.status_out  = (state_q == WAIT_ACK);
        bus.data_ready  = (state_q == WAIT_ACK);
        bus.data_out    = data_q;
        bus.bit_cnt_out = bit_cnt_q;
        bus.words_out   = words_q;
    end
endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Serial-to-parallel stage directly upstream of the 8-entry word queue.
- Accepts one bit per qualified cycle and assembles 8-bit words MSB-first.
- Presents each completed word to the queue through a ready/ack handshake.
- While a word waits for acknowledgement, raises a busy status so the serial source stalls; no bits are lost or reordered.

Parameters:
- WIDTH, 8, bits per assembled word; must match the queue data width.
- CNT_W, 8, width of the delivered-word counter.

Ports:
- clock  input  1  system clock, 10 kHz domain shared with the queue
- reset  input  1  asynchronous, active-high reset
- data_in  input  1  serial data bit
- write_in  input  1  data_in is valid this cycle
- ack_in  input  1  queue has accepted data_out (drives queue enq path)
- data_out  output  WIDTH  assembled word
- data_ready  output  1  data_out holds a complete, unacknowledged word
- status_out  output  1  1 = busy, serial bits not accepted; 0 = accepting
- bit_cnt_out  output  4  bits collected in current word (0..WIDTH-1)
- words_out  output  CNT_W  words delivered since reset, saturating

Behaviour:
- Reset, asynchronous, active-high:
  - State is COLLECT.
  - Shift register = 0, data_out = 0, data_ready = 0, status_out = 0.
  - bit_cnt_out = 0, words_out = 0.
  - Reset mid-word or mid-wait discards all partial or pending data.
- States:
  - COLLECT: status_out=0, data_ready=0.
  - WAIT_ACK: status_out=1, data_ready=1.
- COLLECT:
  - Rising edge with write_in=1: shift register <= {shift[WIDTH-2:0], data_in}; bit_cnt +1.
  - First accepted bit ends in data_out[WIDTH-1]; last accepted bit ends in data_out[0].
  - write_in=0: no change; gaps of any length between bits are allowed.
- Completion:
  - On the edge that accepts bit WIDTH, data_out <= {shift[WIDTH-2:0], data_in}.
  - Same edge: data_ready<=1, status_out<=1, bit_cnt<=0, state -> WAIT_ACK.
  - The word is visible in the cycle immediately after the 8th bit (latency 0 extra cycles).
- WAIT_ACK:
  - write_in is ignored; the bit is dropped and the shift register is unchanged. The source must honour status_out.
  - data_out is held stable.
  - On the edge where ack_in=1: data_ready<=0, status_out<=0, state -> COLLECT.
  - Same edge: words_out +1, saturating at 2^CNT_W-1 (no wrap).
- Simultaneous ack_in=1 and write_in=1 in WAIT_ACK: ack is taken, the bit is ignored. The first bit of the next word is accepted on the following cycle at the earliest.
- ack_in=1 while in COLLECT has no effect.
- After ack, data_out retains the last word until the next word completes; data_out changes only at word completion or reset.
- ack_in held high continuously: each word is acknowledged one cycle after completion, giving 1 busy cycle per word.
- bit_cnt_out counts 0..7 in COLLECT and is 0 in WAIT_ACK.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then write_in=1 for 8 consecutive cycles with bits 1,0,1,1,0,0,1,0 -> next cycle data_out=0xB2, data_ready=1, status_out=1, bit_cnt_out=0, words_out=0. Then ack_in=1 for one cycle -> data_ready=0, status_out=0, words_out=1, data_out still 0xB2.
- Bits 0,1,0,1,0,1,0,1 with write_in low 3 cycles between each bit -> data_out=0x55 only after the 8th bit; bit_cnt_out steps 1..7 in between.
- Complete 0xFF, hold ack_in=0 for 5 cycles while driving write_in=1 with data_in=0 -> data_out stays 0xFF, status_out=1. After ack, send 0x0F -> data_out=0x0F, proving the dropped bits had no effect.
- In WAIT_ACK assert ack_in=1 and write_in=1 (data_in=1) in the same cycle -> ack taken, bit ignored, bit_cnt_out=0 next cycle. Then send 0x81 -> data_out=0x81.
- After 5 accepted bits, pulse reset asynchronously between edges -> all outputs 0 immediately. Then send 0x3C -> data_out=0x3C with no residue from the partial word.
- With ack_in tied high, stream 3 words 0x01,0x02,0x03 back-to-back, respecting status_out -> each data_ready pulse lasts 1 cycle, words_out=3, final data_out=0x03.
